// File: rtl/adc_scan_seq.sv
// adc_scan_seq: multi-channel scan sequencer and averager for the Gowin ADC hard macro.
// Define ADC_SCAN_ALARM_EN to add per-channel low-threshold alarms (thr_lo/alarm ports).
module adc_scan_seq #(
  parameter int                  NUM_CH   = 2,
  parameter int                  ADC_W    = 14,
  parameter int                  AVG_LOG2 = 2,
  parameter logic [NUM_CH*3-1:0] CH_VSEL  = {3'b010, 3'b010},
  parameter logic [NUM_CH-1:0]   CH_MODE  = 2'b01,
  parameter int                  PERIOD_W = 24,
  parameter int                  TIMEOUT  = 4095,
  localparam int                 CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    scan_req,
  input  logic [PERIOD_W-1:0]     period,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic                    adc_req,
  output logic [2:0]              adc_vsel,
  output logic                    adc_mode,
  input  logic                    adc_rdy,
  input  logic [ADC_W-1:0]        adc_value,
  output logic                    busy,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic [ADC_W-1:0]        res_value,
  output logic [NUM_CH*ADC_W-1:0] res_bank,
  output logic                    scan_done,
`ifdef ADC_SCAN_ALARM_EN
  input  logic [NUM_CH*ADC_W-1:0] thr_lo,
  output logic [NUM_CH-1:0]       alarm,
`endif
  output logic                    timeout_err
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_REQ, S_WAIT, S_ACC, S_PUB, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   pend_reg;
  logic [CH_W-1:0]     ch_reg;
  logic [2:0]          vsel_reg;
  logic                mode_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [N_W-1:0]      n_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic [PERIOD_W-1:0] tmr_reg;
  logic                terr_reg;

  logic                tmr_run, auto_trig, start, to_hit;
  logic [NUM_CH-1:0]   pend_after, sel_mask;
  logic [CH_W-1:0]     next_ch;
  logic [ADC_W-1:0]    avg;
  logic [2:0]          vsel_tab [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_vsel_tab
    assign vsel_tab[gi] = CH_VSEL[gi*3 +: 3];
  end

  assign avg        = acc_reg[ACC_W-1:AVG_LOG2];
  assign pend_after = pend_reg & ~(NUM_CH'(1) << ch_reg);
  assign tmr_run    = enable && (period != '0);
  assign auto_trig  = tmr_run && (tmr_reg >= period - PERIOD_W'(1));
  assign start      = (state_reg == S_IDLE) && enable && (scan_req || auto_trig);

  // Lowest pending channel; the mask source depends on whether a scan is starting or continuing.
  always_comb begin
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sel_mask[i]) next_ch = CH_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_mask   = pend_after;
    to_hit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        sel_mask = ch_mask;
        if (start) state_next = (ch_mask != '0) ? S_SETUP : S_DONE;
      end
      S_SETUP: state_next = enable ? S_REQ : S_IDLE;
      S_REQ: begin
        if (!adc_rdy) begin
          state_next = S_WAIT;
        end else if (to_cnt_reg == TO_W'(TIMEOUT)) begin
          to_hit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (adc_rdy) begin
          state_next = enable ? S_ACC : S_IDLE;
        end else if (to_cnt_reg == TO_W'(TIMEOUT)) begin
          to_hit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ACC: begin
        if (!enable)              state_next = S_IDLE;
        else if (n_reg == N_LAST) state_next = S_PUB;
        else                      state_next = S_REQ;
      end
      S_PUB: begin
        if (!enable)                 state_next = S_IDLE;
        else if (pend_after != '0)   state_next = S_SETUP;
        else                         state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      pend_reg   <= '0;
      ch_reg     <= '0;
      vsel_reg   <= '0;
      mode_reg   <= 1'b0;
      acc_reg    <= '0;
      n_reg      <= '0;
      to_cnt_reg <= '0;
      tmr_reg    <= '0;
      terr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (!tmr_run || auto_trig) tmr_reg <= '0;
      else                       tmr_reg <= tmr_reg + PERIOD_W'(1);

      if (start)                   pend_reg <= ch_mask;
      else if (state_reg == S_PUB) pend_reg <= pend_after;

      // Mux selection is loaded only on SETUP entry so it stays frozen through the handshakes.
      if ((state_next == S_SETUP) && (state_reg != S_SETUP)) begin
        ch_reg   <= next_ch;
        vsel_reg <= vsel_tab[next_ch];
        mode_reg <= CH_MODE[next_ch];
      end

      if (((state_next == S_REQ) || (state_next == S_WAIT)) && (state_next != state_reg))
        to_cnt_reg <= '0;
      else if ((state_reg == S_REQ) || (state_reg == S_WAIT))
        to_cnt_reg <= to_cnt_reg + TO_W'(1);

      if (start || (state_reg == S_PUB) || (state_next == S_IDLE)) begin
        acc_reg <= '0;
        n_reg   <= '0;
      end else if (state_reg == S_ACC) begin
        acc_reg <= acc_reg + ACC_W'(adc_value);
        n_reg   <= n_reg + N_W'(1);
      end

      if (to_hit)        terr_reg <= 1'b1;
      else if (scan_req) terr_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
    logic [ADC_W-1:0] val_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        val_reg <= '0;
      else if ((state_reg == S_PUB) && (ch_reg == CH_W'(gi)))
        val_reg <= avg;
    end
    assign res_bank[gi*ADC_W +: ADC_W] = val_reg;
  end

`ifdef ADC_SCAN_ALARM_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_alarm
    logic [ADC_W-1:0] thr;
    logic [ADC_W:0]   thr_hi_wide;
    logic [ADC_W-1:0] thr_hi;
    logic             alarm_reg;
    assign thr         = thr_lo[gi*ADC_W +: ADC_W];
    assign thr_hi_wide = {1'b0, thr} + (ADC_W + 1)'(16);
    assign thr_hi      = thr_hi_wide[ADC_W] ? '1 : thr_hi_wide[ADC_W-1:0];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        alarm_reg <= 1'b0;
      end else if ((state_reg == S_PUB) && (ch_reg == CH_W'(gi))) begin
        if (avg < thr)          alarm_reg <= 1'b1;
        else if (avg >= thr_hi) alarm_reg <= 1'b0;
      end
    end
    assign alarm[gi] = alarm_reg;
  end
`endif

  assign adc_req     = (state_reg == S_REQ);
  assign adc_vsel    = vsel_reg;
  assign adc_mode    = mode_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign res_valid   = (state_reg == S_PUB);
  assign res_ch      = (state_reg == S_PUB) ? ch_reg : '0;
  assign res_value   = (state_reg == S_PUB) ? avg : '0;
  assign scan_done   = (state_reg == S_DONE);
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed self-checking bench for adc_scan_seq with a behavioural ADC macro model.
module tb_adc_scan_seq;
  localparam int NUM_CH = 2, ADC_W = 14, AVG_LOG2 = 2, PERIOD_W = 24, TIMEOUT = 4095;
  localparam logic [5:0] CH_VSEL = {3'b101, 3'b010};
  localparam logic [1:0] CH_MODE = 2'b01;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, scan_req = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic [1:0] ch_mask = '0;
  logic adc_req, adc_mode, adc_rdy, busy, res_valid, scan_done, timeout_err;
  logic [2:0] adc_vsel;
  logic [ADC_W-1:0] adc_value, res_value;
  logic [0:0] res_ch;
  logic [2*ADC_W-1:0] res_bank;
`ifdef ADC_SCAN_ALARM_EN
  logic [2*ADC_W-1:0] thr_lo = {14'd0, 14'd500};
  logic [1:0] alarm;
`endif

  adc_scan_seq #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .CH_VSEL(CH_VSEL),
                 .CH_MODE(CH_MODE), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .scan_req(scan_req), .period(period),
    .ch_mask(ch_mask), .adc_req(adc_req), .adc_vsel(adc_vsel), .adc_mode(adc_mode),
    .adc_rdy(adc_rdy), .adc_value(adc_value), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_value(res_value), .res_bank(res_bank), .scan_done(scan_done),
`ifdef ADC_SCAN_ALARM_EN
    .thr_lo(thr_lo), .alarm(alarm),
`endif
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int err_cnt = 0, chk_cnt = 0;

  // ADC macro model: rdy drops 2 cycles after req, rises 5 cycles later with the sample.
  int m_phase = 0, m_cnt = 0, stab_err = 0, ch0_idx = 0, req_cycles = 0, ch0_fixed = -1;
  bit stuck = 1'b0;
  logic [2:0] m_vsel = '0;
  logic m_mode = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      adc_rdy = 1'b1; adc_value = '0; m_phase = 0; ch0_idx = 0;
    end else begin
      if (adc_req) req_cycles++;
      if (!busy) ch0_idx = 0;
      case (m_phase)
        0: if (adc_req) begin
          m_vsel = adc_vsel; m_mode = adc_mode; m_cnt = 0;
          if (!((m_vsel == 3'b010 && m_mode) || (m_vsel == 3'b101 && !m_mode))) stab_err++;
          m_phase = stuck ? 3 : 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == 2) begin adc_rdy = 1'b0; m_cnt = 0; m_phase = 2; end
        end
        2: begin
          m_cnt++;
          if (adc_req) stab_err++;
          if (m_cnt == 5) begin
            if (m_vsel == 3'b010) begin
              adc_value = (ch0_fixed >= 0) ? 14'(ch0_fixed) : 14'(100 + 2 * ch0_idx);
              ch0_idx++;
            end else begin
              adc_value = 14'd8000;
            end
            adc_rdy = 1'b1; m_phase = 0;
          end
        end
        default: if (!adc_req) m_phase = 0;
      endcase
      if (m_phase != 0 && (adc_vsel !== m_vsel || adc_mode !== m_mode)) stab_err++;
    end
  end

  // Result / done monitor
  int cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0;
  int res_cnt [2] = '{0, 0};
  int res_seq [$];
  logic [ADC_W-1:0] res_last [2] = '{14'd0, 14'd0};
  always @(negedge clk) begin
    cyc++;
    if (res_valid) begin
      res_cnt[res_ch]++; res_last[res_ch] = res_value; res_seq.push_back(int'(res_ch));
      $display("res_valid ch=%0d value=%0d", res_ch, res_value);
    end
    if (scan_done) begin
      done_cnt++; prev_done = last_done; last_done = cyc;
      $display("scan_done at cycle %0d", cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input string tag, input logic [1:0] m);
    bit found;
    found = 1'b0;
    ch_mask = m; scan_req = 1'b1; tick(); scan_req = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (scan_done) found = 1'b1; else tick();
    end
    check(tag, 64'(found), 64'd1);
    repeat (2) tick();
  endtask

  initial begin
    int b_done, b_req, b0, b1, b_seq;
    bit found;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_adc_req", 64'(adc_req), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_res_value", 64'(res_value), 0);
    check("rst_scan_done", 64'(scan_done), 0);
    check("rst_res_bank", 64'(res_bank), 0);
    check("rst_timeout_err", 64'(timeout_err), 0);
    check("rst_vsel_mode", 64'({adc_vsel, adc_mode}), 0);
    reset = 1'b0; enable = 1'b1; tick();

    // Full scan of both channels
    b_seq = res_seq.size(); b_done = done_cnt;
    ch_mask = 2'b11; scan_req = 1'b1; tick(); scan_req = 1'b0;
    check("start_busy", 64'(busy), 1);
    check("setup_no_req", 64'(adc_req), 0);
    check("setup_vsel_ch0", 64'(adc_vsel), 64'(3'b010));
    check("setup_mode_ch0", 64'(adc_mode), 1);
    repeat (10) tick();
    scan_req = 1'b1; tick(); scan_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (scan_done) found = 1'b1; else tick();
    end
    check("scan1_done_seen", 64'(found), 1);
    check("scan1_busy_at_done", 64'(busy), 0);
    tick();
    check("scan1_done_pulse", 64'(scan_done), 0);
    repeat (100) tick();
    check("scan1_done_once", 64'(done_cnt - b_done), 1);
    check("scan1_res_count", 64'(res_seq.size() - b_seq), 2);
    if (res_seq.size() >= b_seq + 2) begin
      check("scan1_order0", 64'(res_seq[b_seq]), 0);
      check("scan1_order1", 64'(res_seq[b_seq + 1]), 1);
    end
    check("scan1_ch0_avg", 64'(res_last[0]), 103);
    check("scan1_ch1_avg", 64'(res_last[1]), 8000);
    check("scan1_bank", 64'(res_bank), 64'({14'd8000, 14'd103}));
    check("vsel_mode_stable", 64'(stab_err), 0);

    // Empty mask
    b_req = req_cycles; b_done = done_cnt;
    ch_mask = 2'b00; scan_req = 1'b1; tick(); scan_req = 1'b0;
    check("mask0_done", 64'(scan_done), 1);
    check("mask0_busy", 64'(busy), 0);
    tick();
    check("mask0_done_pulse", 64'(scan_done), 0);
    repeat (3) tick();
    check("mask0_no_req", 64'(req_cycles - b_req), 0);

    // Auto trigger, ch1 only
    b_done = done_cnt; b0 = res_cnt[0]; b1 = res_cnt[1];
    ch_mask = 2'b10; period = 24'd1000;
    repeat (3200) tick();
    check("auto_done_count", 64'(done_cnt - b_done), 3);
    check("auto_interval", 64'(last_done - prev_done), 1000);
    check("auto_ch0_none", 64'(res_cnt[0] - b0), 0);
    check("auto_ch1_count", 64'(res_cnt[1] - b1), 3);
    check("auto_ch1_avg", 64'(res_last[1]), 8000);
    period = '0; b_done = done_cnt;
    repeat (2500) tick();
    check("period0_no_scan", 64'(done_cnt - b_done), 0);
    check("auto_vsel_mode_stable", 64'(stab_err), 0);

    // Handshake timeout
    stuck = 1'b1; b_req = req_cycles; b_done = done_cnt; b0 = res_cnt[0];
    ch_mask = 2'b01; scan_req = 1'b1; tick(); scan_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (timeout_err) found = 1'b1; else tick();
    end
    check("timeout_seen", 64'(found), 1);
    check("timeout_req_low", 64'(adc_req), 0);
    check("timeout_busy_low", 64'(busy), 0);
    repeat (3) tick();
    check("timeout_req_cycles", 64'(req_cycles - b_req), 64'(TIMEOUT + 1));
    check("timeout_no_done", 64'(done_cnt - b_done), 0);
    check("timeout_no_res", 64'(res_cnt[0] - b0), 0);
    check("timeout_bank_kept", 64'(res_bank), 64'({14'd8000, 14'd103}));
    check("timeout_sticky", 64'(timeout_err), 1);
    stuck = 1'b0;
    ch_mask = 2'b00; scan_req = 1'b1; tick(); scan_req = 1'b0;
    check("timeout_cleared", 64'(timeout_err), 0);
    repeat (3) tick();

    // Enable dropped during ch0 WAIT
    b_done = done_cnt; b0 = res_cnt[0]; b1 = res_cnt[1];
    ch_mask = 2'b11; scan_req = 1'b1; tick(); scan_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (!adc_rdy) found = 1'b1; else tick();
    end
    check("abort_wait_seen", 64'(found), 1);
    enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (!busy) found = 1'b1; else tick();
    end
    check("abort_idle_seen", 64'(found), 1);
    check("abort_after_rdy", 64'(adc_rdy), 1);
    b_req = req_cycles;
    repeat (20) tick();
    check("abort_no_req", 64'(req_cycles - b_req), 0);
    check("abort_no_res", 64'((res_cnt[0] - b0) + (res_cnt[1] - b1)), 0);
    check("abort_no_done", 64'(done_cnt - b_done), 0);
    enable = 1'b1; tick();
    run_scan("rescan_done_seen", 2'b11);
    check("rescan_ch0_avg", 64'(res_last[0]), 103);
    check("rescan_ch1_avg", 64'(res_last[1]), 8000);

`ifdef ADC_SCAN_ALARM_EN
    check("alarm_rst", 64'(alarm), 0);
    ch0_fixed = 400; run_scan("alarm400_done", 2'b01);
    check("alarm400_set", 64'(alarm), 1);
    ch0_fixed = 510; run_scan("alarm510_done", 2'b01);
    check("alarm510_hold", 64'(alarm), 1);
    ch0_fixed = 520; run_scan("alarm520_done", 2'b01);
    check("alarm520_clear", 64'(alarm), 0);
    ch0_fixed = -1;
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
